// File: rtl/serial_pg_adder.sv
// Bit-serial adder: one carry-propagate cell, LSB-first, WIDTH cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module cp (
    input  logic p,
    input  logic g,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = p ^ cin;
    assign cout = g | (p & cin);
endmodule

module serial_pg_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               cp_p;
    logic               cp_g;
    logic               cp_sum;
    logic               cp_cout;
    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   sum_shifted;

    assign cp_p        = a_sr[0] ^ b_sr[0];
    assign cp_g        = a_sr[0] & b_sr[0];
    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
    assign accept      = start && (state != RUN);
    assign sum_shifted = {cp_sum, sum_sr[WIDTH-1:1]};

    cp u_cp (
        .p    (cp_p),
        .g    (cp_g),
        .cin  (carry),
        .sum  (cp_sum),
        .cout (cp_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_sr <= sum_shifted;
            carry  <= cp_cout;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            cnt    <= cnt + CNT_W'(1);
            // Final bit lands directly in the result; sum_sr alone would lag one cycle.
            if (last_bit) begin
                sum  <= sum_shifted;
                cout <= cp_cout;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= carry ^ cp_cout;
`endif
            end
        end
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_pg_adder.sv
// Directed self-checking bench for serial_pg_adder (WIDTH=8).
// Checks ovf as well when SERIAL_ADD_OVF_EN is defined.

module tb_serial_pg_adder;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_pg_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done is seen; first counted negedge is RUN cycle 1.
    task automatic wait_done(input string tag, output int lat, output int busy_n);
        bit seen;
        seen   = 0;
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        if (!seen) check_val({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        int bn;
        launch(av, bv, cv);
        wait_done(tag, lat, bn);
        check_val({tag, "_latency"}, lat, 9);
        check_val({tag, "_busy_cycles"}, bn, 8);
        check_val({tag, "_sum"}, 32'(sum), 32'(es));
        check_val({tag, "_cout"}, 32'(cout), 32'(ec));
        check_val({tag, "_ready_done"}, 32'(ready), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        check_val({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected x expectation for %s", tag);
`endif
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_sum_held"}, 32'(sum), 32'(es));
        check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int bn;
        int done_seen;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        // T1..T3 plus extra boundary patterns
        run_op("t1", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t3", 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1);
        run_op("min_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run_op("neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op("all_ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // T4: start pulsed mid-RUN is ignored
        launch(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        check_val("t4_busy_ignore", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done("t4", lat, bn);
        check_val("t4_latency", 3 + lat, 9);
        check_val("t4_sum", 32'(sum), 32'h46);
        check_val("t4_cout", 32'(cout), 32'd0);
        @(negedge clk);

        // T5: reset mid-RUN clears outputs and suppresses done
        launch(8'h3C, 8'h05, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_done", 32'(done), 32'd0);
        check_val("t5_sum", 32'(sum), 32'd0);
        check_val("t5_cout", 32'(cout), 32'd0);
        check_val("t5_ready", 32'(ready), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        check_val("t5_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_val("t5_no_done", done_seen, 0);

        // T6: start held through DONE launches the next add back-to-back
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        wait_done("t6a", lat, bn);
        check_val("t6a_latency", lat, 9);
        check_val("t6a_sum", 32'(sum), 32'h03);
        a = 8'h10;
        b = 8'h20;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t6b", lat, bn);
        check_val("t6b_gap", lat, 9);
        check_val("t6b_sum", 32'(sum), 32'h30);
        check_val("t6b_cout", 32'(cout), 32'd0);
        @(negedge clk);
        check_val("t6b_done_pulse", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
